// File: rtl/conv_pkg.sv
// Shared definitions for the tiny-model convolution layers: FSM states, clog2 and the
// fixed-point shift/saturate/ReLU helper.
package conv_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMac  = 2'd1,
        StFin  = 2'd2,
        StOut  = 2'd3
    } conv_state_e;

    function automatic int clog2(input int unsigned value);
        int res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Arithmetic shift right (floor), clamp to the signed data_w range, optional ReLU.
    function automatic logic signed [63:0] shift_sat(input logic signed [63:0] acc,
                                                     input int unsigned        frac_w,
                                                     input int unsigned        data_w,
                                                     input logic               relu);
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r     = acc >>> frac_w;
        max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (data_w - 1));
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        if (relu && (r < 64'sd0)) begin
            r = 64'sd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv1x1_mac_lane.sv
// One output-channel lane: bias preload, serial multiply-accumulate over input channels,
// and the shift/saturate/ReLU result stage.
module conv1x1_mac_lane
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned RELU   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [DATA_W-1:0] result
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;

    assign prod = x * w;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            // Bias is aligned to the product's 2*FRAC_W binary point.
            acc_q <= ACC_W'(bias) <<< FRAC_W;
        end else if (en) begin
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

    assign result = DATA_W'(shift_sat(64'(acc_q), FRAC_W, DATA_W, RELU != 0));

endmodule

// File: rtl/conv1x1_layer_tm.sv
// Pointwise convolution layer: COUT parallel MAC lanes walk CIN inputs serially, with a
// run-time loadable weight/bias file and valid/ready handshakes on both sides.
module conv1x1_layer_tm
    import conv_pkg::*;
#(
    parameter int unsigned CIN    = 12,
    parameter int unsigned COUT   = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned RELU   = 0,
    localparam int unsigned CFG_AW = clog2(CIN * COUT + COUT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CIN*DATA_W-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COUT*DATA_W-1:0]   out_data,
    input  logic                     cfg_we,
    input  logic [CFG_AW-1:0]        cfg_addr,
    input  logic [DATA_W-1:0]        cfg_wdata,
    output logic                     busy
);

    localparam int unsigned CI_W = (CIN > 1) ? clog2(CIN) : 1;

    conv_state_e state_q, state_d;

    logic [CI_W-1:0]          ci_q;
    logic signed [DATA_W-1:0] x_q [CIN];
    logic signed [DATA_W-1:0] w_q [COUT][CIN];
    logic signed [DATA_W-1:0] b_q [COUT];
    logic [COUT*DATA_W-1:0]   out_data_q;
    logic                     out_valid_q;

    logic                     in_hs;
    logic                     out_hs;
    logic                     cfg_wr;
    logic                     mac_en;
    logic signed [DATA_W-1:0] cur_x;
    logic signed [DATA_W-1:0] lane_res [COUT];

    assign in_ready  = (state_q == StIdle) && !rst;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;
    // A write that collides with an accepted pixel is dropped so the pixel sees stable weights.
    assign cfg_wr    = cfg_we && (state_q == StIdle) && !in_hs;
    assign mac_en    = (state_q == StMac);
    assign cur_x     = x_q[ci_q];
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_hs) state_d = StMac;
            StMac:   if (ci_q == CI_W'(CIN - 1)) state_d = StFin;
            StFin:   state_d = StOut;
            StOut:   if (out_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ci_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int unsigned i = 0; i < CIN; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (in_hs) begin
                ci_q <= '0;
                for (int unsigned i = 0; i < CIN; i++) begin
                    x_q[i] <= in_data[i*DATA_W +: DATA_W];
                end
            end else if (mac_en) begin
                ci_q <= ci_q + CI_W'(1);
            end
            if (state_q == StFin) begin
                for (int unsigned o = 0; o < COUT; o++) begin
                    out_data_q[o*DATA_W +: DATA_W] <= lane_res[o];
                end
                out_valid_q <= 1'b1;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Weight/bias register file; unmapped addresses match no entry and are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned o = 0; o < COUT; o++) begin
                b_q[o] <= '0;
                for (int unsigned i = 0; i < CIN; i++) begin
                    w_q[o][i] <= '0;
                end
            end
        end else if (cfg_wr) begin
            for (int unsigned o = 0; o < COUT; o++) begin
                if (cfg_addr == CFG_AW'(CIN * COUT + o)) begin
                    b_q[o] <= cfg_wdata;
                end
                for (int unsigned i = 0; i < CIN; i++) begin
                    if (cfg_addr == CFG_AW'(o * CIN + i)) begin
                        w_q[o][i] <= cfg_wdata;
                    end
                end
            end
        end
    end

    for (genvar o = 0; o < COUT; o++) begin : g_lane
        conv1x1_mac_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .ACC_W  (ACC_W),
            .RELU   (RELU)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (in_hs),
            .en     (mac_en),
            .x      (cur_x),
            .w      (w_q[o][ci_q]),
            .bias   (b_q[o]),
            .result (lane_res[o])
        );
    end

endmodule

// File: tb/tb_conv1x1_layer_tm.sv
// Bench for conv1x1_layer_tm: a RELU=0 and a RELU=1 instance share stimulus and are checked
// every cycle against an arithmetic reference model and a transaction-level timing model.
module tb_conv1x1_layer_tm;

    localparam int CIN    = 12;
    localparam int COUT   = 16;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int ACC_W  = 40;
    localparam int CFG_AW = conv_pkg::clog2(CIN * COUT + COUT);
    localparam int NADDR  = CIN * COUT + COUT;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic cfg_we;
    logic [CIN*DATA_W-1:0]  in_data;
    logic [CFG_AW-1:0]      cfg_addr;
    logic [DATA_W-1:0]      cfg_wdata;
    logic in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
    logic [COUT*DATA_W-1:0] out_data0, out_data1;

    int total = 0;
    int bad   = 0;

    int  mw [COUT][CIN];
    int  mb [COUT];
    logic [COUT*DATA_W-1:0] q0 [$];
    logic [COUT*DATA_W-1:0] q1 [$];
    bit  pend = 0;
    bit  chk_en = 0;
    bit  rand_rdy = 0;
    bit  rdy_hold = 1;
    int  cyc = 0;
    int  hs_cyc = 0;

    conv1x1_layer_tm #(.CIN(CIN), .COUT(COUT), .DATA_W(DATA_W), .FRAC_W(FRAC_W),
                       .ACC_W(ACC_W), .RELU(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .busy(busy0)
    );

    conv1x1_layer_tm #(.CIN(CIN), .COUT(COUT), .DATA_W(DATA_W), .FRAC_W(FRAC_W),
                       .ACC_W(ACC_W), .RELU(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_hold;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [COUT*DATA_W-1:0] got,
                           input logic [COUT*DATA_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Reference: out[o] = clamp(floor((B[o]*2^F + sum x[i]*W[o][i]) / 2^F)), ReLU optional.
    function automatic logic [COUT*DATA_W-1:0] model(input logic [CIN*DATA_W-1:0] din,
                                                     input bit relu);
        logic [COUT*DATA_W-1:0] res;
        logic [DATA_W-1:0]      xs;
        longint acc, r, max_v, min_v;
        max_v = (longint'(1) << (DATA_W - 1)) - 1;
        min_v = -(longint'(1) << (DATA_W - 1));
        res = '0;
        for (int o = 0; o < COUT; o++) begin
            acc = longint'(mb[o]) * (longint'(1) << FRAC_W);
            for (int i = 0; i < CIN; i++) begin
                xs  = din[i*DATA_W +: DATA_W];
                acc += longint'($signed(xs)) * longint'(mw[o][i]);
            end
            r = acc >>> FRAC_W;
            if (r > max_v) r = max_v;
            if (r < min_v) r = min_v;
            if (relu && r < 0) r = 0;
            res[o*DATA_W +: DATA_W] = r[DATA_W-1:0];
        end
        return res;
    endfunction

    function automatic longint ch(input logic [COUT*DATA_W-1:0] v, input int o);
        logic signed [DATA_W-1:0] s;
        s = v[o*DATA_W +: DATA_W];
        return longint'(s);
    endfunction

    function automatic logic [CIN*DATA_W-1:0] uni_px(input int v);
        logic [CIN*DATA_W-1:0] p;
        for (int i = 0; i < CIN; i++) p[i*DATA_W +: DATA_W] = DATA_W'(v);
        return p;
    endfunction

    // Transaction-level checker: one pixel outstanding, result CIN+2 cycles after acceptance.
    always @(negedge clk) begin
        if (chk_en) begin
            bit ev, ihs, ohs;
            ev = pend && (cyc - hs_cyc >= CIN + 2);
            chk("out_valid0", out_valid0, ev);
            chk("out_valid1", out_valid1, ev);
            chk("busy0", busy0, pend);
            chk("busy1", busy1, pend);
            chk("in_ready0", in_ready0, !pend && !rst);
            chk("in_ready1", in_ready1, !pend && !rst);
            if (ev && q0.size() > 0) begin
                chk_vec("out_data0", out_data0, q0[0]);
                chk_vec("out_data1", out_data1, q1[0]);
            end
            ihs = in_valid && !pend && !rst;
            ohs = ev && out_ready;
            if (rst) begin
                pend = 0;
                q0.delete();
                q1.delete();
            end else if (ohs) begin
                pend = 0;
                if (q0.size() > 0) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                end
            end else if (ihs) begin
                pend = 1;
                hs_cyc = cyc;
                q0.push_back(model(in_data, 0));
                q1.push_back(model(in_data, 1));
            end
        end
    end

    task automatic clear_model();
        for (int o = 0; o < COUT; o++) begin
            mb[o] = 0;
            for (int i = 0; i < CIN; i++) mw[o][i] = 0;
        end
    endtask

    // All driver tasks start and end at #1 after a rising edge.
    task automatic cfg_write(input int addr, input int val, input bit upd);
        logic signed [DATA_W-1:0] v16;
        v16 = DATA_W'(val);
        cfg_we = 1'b1;
        cfg_addr = CFG_AW'(addr);
        cfg_wdata = v16;
        if (upd) begin
            if (addr < CIN * COUT) mw[addr / CIN][addr % CIN] = int'(v16);
            else if (addr < NADDR) mb[addr - CIN * COUT] = int'(v16);
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic load_uniform(input int w, input int b);
        for (int a = 0; a < CIN * COUT; a++) cfg_write(a, w, 1);
        for (int o = 0; o < COUT; o++) cfg_write(CIN * COUT + o, b, 1);
    endtask

    task automatic send_pixel(input logic [CIN*DATA_W-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        while (!in_ready0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) chk("accept timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic get_result(output logic [COUT*DATA_W-1:0] d0,
                              output logic [COUT*DATA_W-1:0] d1);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid0) chk("result timeout", 0, 1);
        d0 = out_data0;
        d1 = out_data1;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk); #1;
        while (pend && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (pend) chk("idle timeout", 0, 1);
    endtask

    initial begin
        logic [COUT*DATA_W-1:0] d0, d1;
        logic [CIN*DATA_W-1:0]  px;
        int ohs_c, ihs_c, n;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_wdata = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1;
        @(negedge clk);
        chk("reset out_valid", out_valid0, 0);
        chk("reset out_data", out_data0, 0);
        chk("reset busy", busy0, 0);
        chk("reset in_ready", in_ready0, 1);
        @(posedge clk); #1;

        // Unit weights, unit inputs: 12.0 per channel.
        load_uniform(256, 0);
        send_pixel(uni_px(256));
        get_result(d0, d1);
        chk("unit ch0", ch(d0, 0), 3072);
        chk("unit ch15", ch(d0, 15), 3072);

        // W[o][i]=(o+1), B[o]=o, x=0.5: out[o] = 6(o+1)+o.
        for (int o = 0; o < COUT; o++) begin
            for (int i = 0; i < CIN; i++) cfg_write(o * CIN + i, (o + 1) * 256, 1);
            cfg_write(CIN * COUT + o, o * 256, 1);
        end
        send_pixel(uni_px(128));
        get_result(d0, d1);
        chk("ramp ch0", ch(d0, 0), 1536);
        chk("ramp ch15", ch(d0, 15), 28416);

        load_uniform(32512, 0);
        send_pixel(uni_px(32512));
        get_result(d0, d1);
        chk("sat pos relu0", ch(d0, 3), 32767);
        chk("sat pos relu1", ch(d1, 3), 32767);

        load_uniform(-256, 0);
        send_pixel(uni_px(256));
        get_result(d0, d1);
        chk("neg relu0", ch(d0, 0), -3072);
        chk("neg relu1", ch(d1, 0), 0);

        // Backpressure: hold the result 20 cycles while a second pixel waits.
        load_uniform(256, 0);
        rdy_hold = 0;
        send_pixel(uni_px(256));
        n = 0;
        @(negedge clk);
        while (!out_valid0 && n < 300) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data = uni_px(512);
        repeat (20) @(negedge clk);
        chk("bp in_ready", in_ready0, 0);
        chk("bp held ch0", ch(out_data0, 0), 3072);
        @(posedge clk); #1;
        rdy_hold = 1;
        ohs_c = -100; ihs_c = 0; n = 0;
        @(negedge clk);
        while (!in_ready0 && n < 100) begin
            if (out_valid0 && out_ready) ohs_c = cyc;
            @(negedge clk);
            n++;
        end
        ihs_c = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp accept gap", ihs_c - ohs_c, 1);
        get_result(d0, d1);
        chk("bp second ch0", ch(d0, 0), 6144);

        // Config write while busy is dropped; in IDLE it lands; unmapped address ignored.
        send_pixel(uni_px(256));
        cfg_write(0, 512, 0);
        get_result(d0, d1);
        chk("busy write dropped", ch(d0, 0), 3072);
        cfg_write(0, 512, 1);
        cfg_write(NADDR, 1234, 1);
        send_pixel(uni_px(256));
        get_result(d0, d1);
        chk("idle write ch0", ch(d0, 0), 3328);
        chk("idle write ch1", ch(d0, 1), 3072);

        // Reset in the middle of MAC (ci=5).
        send_pixel(uni_px(256));
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort out_valid", out_valid0, 0);
        chk("abort busy", busy0, 0);
        chk("abort in_ready", in_ready0, 1);
        @(posedge clk); #1;
        for (int o = 0; o < COUT; o++) cfg_write(CIN * COUT + o, 512, 1);
        send_pixel(uni_px(256));
        get_result(d0, d1);
        chk("bias only ch0", ch(d0, 0), 512);
        chk("bias only ch7", ch(d0, 7), 512);

        // Randomised traffic with random config and random downstream readiness.
        rand_rdy = 1;
        for (int t = 0; t < 30; t++) begin
            bit wide;
            wide = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 24; k++) begin
                cfg_write(int'($urandom_range(0, (1 << CFG_AW) - 1)),
                          wide ? int'($urandom) : int'($urandom_range(0, 1023)) - 512, 1);
            end
            for (int i = 0; i < CIN; i++) begin
                px[i*DATA_W +: DATA_W] = wide ? DATA_W'($urandom)
                                              : DATA_W'(int'($urandom_range(0, 2047)) - 1024);
            end
            send_pixel(px);
            wait_idle();
        end
        rand_rdy = 0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv1x1_layer_tm.md
Name: conv1x1_layer_tm

Overview:
- Parametrised pointwise (1x1) convolution layer for the tiny-model datapath.
- Computes COUT output channels from CIN input channels per pixel, plus per-channel bias and optional ReLU.
- Uses COUT parallel MAC lanes and walks the CIN inputs serially, so area scales with COUT, not CIN*COUT.
- Weights and biases are run-time loadable through a config write port, not fixed elaboration constants.
- Inputs and outputs use valid/ready handshakes, so it chains with other layers under backpressure.

Parameters:
- CIN, 12: input channel count (>=1).
- COUT, 16: output channel count (>=1).
- DATA_W, 16: signed fixed-point width of activations, weights and bias.
- FRAC_W, 8: fractional bits of all DATA_W quantities.
- ACC_W, 40: signed accumulator width; must be >= 2*DATA_W + clog2(CIN) + 1.
- RELU, 0: 1 = clamp negative results to zero.
- CFG_AW, derived: clog2(CIN*COUT + COUT), config address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_data  in  CIN*DATA_W  packed channels; channel i at [i*DATA_W +: DATA_W]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  COUT*DATA_W  packed results; channel o at [o*DATA_W +: DATA_W]
- cfg_we  in  1  config write strobe
- cfg_addr  in  CFG_AW  config address
- cfg_wdata  in  DATA_W  weight or bias value
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: in_ready=0 during rst, then 1 in IDLE; out_valid=0; out_data=0; busy=0; state=IDLE.
- Reset clears weights and biases to 0.
- Config address map:
  - addr = o*CIN + i writes weight W[o][i].
  - addr = CIN*COUT + o writes bias B[o].
  - Out-of-range addresses are ignored.
- Config writes are applied only when state==IDLE and no input handshake occurs in the same cycle; otherwise they are dropped. Software must poll busy.
- States:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) latches in_data into an input register, loads acc[o] = sign_ext(B[o]) << FRAC_W, sets ci=0, goes to MAC.
  - MAC: each cycle, acc[o] += x[ci]*W[o][ci] for all o (full-precision signed product, sign-extended to ACC_W). ci increments; after ci==CIN-1, go to FIN.
  - FIN: for each o, r = acc[o] >>> FRAC_W (arithmetic shift, truncate toward -inf). Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. If RELU, negatives become 0. Register into out_data, set out_valid=1, go to OUT.
  - OUT: hold out_data and out_valid stable until out_ready. On the handshake, clear out_valid and go to IDLE.
- Latency: input handshake at cycle T gives out_valid=1 at T+CIN+2. Throughput is one pixel per CIN+3 cycles with out_ready held high.
- in_ready is 0 in MAC, FIN and OUT. in_valid in those states is ignored, so the upstream holds its data.
- out_ready without out_valid has no effect.
- rst asserted mid-operation aborts the computation next edge. All outputs return to reset values and partial results are discarded.
- CIN=1: MAC lasts exactly one cycle.

Decomposition:
- Shared package conv_pkg holds:
  - clog2 function;
  - state encoding localparams (IDLE, MAC, FIN, OUT);
  - the saturate/round function, reused by other layers.
- Sub-module conv1x1_mac_lane, one per output channel, instantiated COUT times. It contains the accumulator, the multiply-add, and the shift/saturate/ReLU stage, with inputs clr, en, x, w, bias.
- The top level holds the FSM, channel counter, input register, weight/bias register file and config decode.

Test Plan:
- Defaults, all weights 1.0 (256), all biases 0, inputs all 1.0 -> every out_data channel = 12.0 (3072); out_valid exactly 14 cycles after the input handshake.
- W[o][i] = (o+1)*256, B[o] = o*256, input i = 0.5 (128) -> out[o] = 6*(o+1) + o (e.g. out[15] = 111.0 = 28416).
- Saturation and ReLU:
  - weights 127.0, inputs 127.0, RELU=0 -> out = 32767.
  - weights -1.0, inputs 1.0, RELU=1 -> out = 0.
  - same with RELU=0 -> out = -12.0 (-3072).
- Backpressure: out_ready held 0 for 20 cycles -> out_data stable, in_ready=0, second in_valid not accepted; release -> second pixel accepted the cycle after the output handshake.
- Config while busy: cfg_we to W[0][0] during MAC -> dropped, result unchanged; same write in IDLE -> next result reflects it. Out-of-range address -> no change.
- Reset mid-MAC (ci=5) -> next cycle out_valid=0, busy=0, in_ready=1, weights zeroed; a new pixel with only bias rewritten to 2.0 -> out = 2.0.
